// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out shift register.
package piso_pkg;

   typedef enum logic {PISO_IDLE = 1'b0, PISO_SHIFT = 1'b1} piso_state_t;

   // Bits needed to hold 0..width-1, never less than one.
   function automatic int piso_count_width(input int width);
      int w;
      w = 1;
      while ((1 << w) < width) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/piso_hold_register.sv
// One-word staging register with a full flag, feeding the shifter's next word.
module piso_hold_register #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             write,
   input  logic [WIDTH-1:0] data_in,
   input  logic             take,
   output logic [WIDTH-1:0] data,
   output logic             full
);

   // Capture on write, release on take; the two never coincide.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         data <= {WIDTH{1'b0}};
         full <= 1'b0;
      end else if (write) begin
         data <= data_in;
         full <= 1'b1;
      end else if (take) begin
         full <= 1'b0;
      end
   end

endmodule

// File: rtl/piso_shift_register.sv
// Parametrised PISO shifter with valid/ready load and valid/last bit framing.
// Optional back-to-back streaming through a hold register: define PISO_PRELOAD_EN.
module piso_shift_register
   import piso_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             en,
   input  logic [WIDTH-1:0] parallel_in,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             output_bit,
   output logic             output_valid,
   output logic             output_last,
   output logic             busy
);

   localparam int            CW         = piso_count_width(WIDTH);
   localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

   piso_state_t      state_r, state_s;
   logic [WIDTH-1:0] shreg_r, shreg_s;
   logic [CW-1:0]    count_r, count_s;
   logic             bit_r, bit_s;
   logic             valid_r, valid_s;
   logic             last_r, last_s;
   logic             alive_r;
   logic             accept_s;
   logic             at_last_s;

`ifdef PISO_PRELOAD_EN
   logic             hold_write_s;
   logic             hold_take_s;
   logic             hold_full_s;
   logic [WIDTH-1:0] hold_data_s;

   piso_hold_register #(.WIDTH(WIDTH)) u_hold (
      .clock   (clock),
      .reset_n (reset_n),
      .write   (hold_write_s),
      .data_in (parallel_in),
      .take    (hold_take_s),
      .data    (hold_data_s),
      .full    (hold_full_s)
   );

   assign load_ready = alive_r & ~hold_full_s;
`else
   assign load_ready = alive_r & (state_r == PISO_IDLE);
`endif

   assign accept_s     = load_valid & load_ready & en;
   assign at_last_s    = (count_r == LAST_COUNT);
   assign busy         = (state_r == PISO_SHIFT);
   assign output_bit   = bit_r;
   assign output_valid = valid_r;
   assign output_last  = last_r;

   // Keeps load_ready low until the first clock after reset release.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         alive_r <= 1'b0;
      end else begin
         alive_r <= 1'b1;
      end
   end

   // Next-state, shift and framing decisions; en low holds everything.
   always_comb begin
      state_s = state_r;
      shreg_s = shreg_r;
      count_s = count_r;
      bit_s   = bit_r;
      valid_s = valid_r;
      last_s  = last_r;
`ifdef PISO_PRELOAD_EN
      hold_write_s = 1'b0;
      hold_take_s  = 1'b0;
`endif
      if (en) begin
         valid_s = 1'b0;
         last_s  = 1'b0;
         case (state_r)
            PISO_IDLE: begin
               if (accept_s) begin
                  shreg_s = parallel_in;
                  count_s = {CW{1'b0}};
                  state_s = PISO_SHIFT;
               end else begin
                  state_s = PISO_IDLE;
               end
            end
            PISO_SHIFT: begin
               if (MSB_FIRST) begin
                  bit_s   = shreg_r[WIDTH-1];
                  shreg_s = {shreg_r[WIDTH-2:0], 1'b0};
               end else begin
                  bit_s   = shreg_r[0];
                  shreg_s = {1'b0, shreg_r[WIDTH-1:1]};
               end
               valid_s = 1'b1;
               last_s  = at_last_s;
               count_s = count_r + CW'(1);
               if (at_last_s) begin
                  count_s = {CW{1'b0}};
`ifdef PISO_PRELOAD_EN
                  if (hold_full_s) begin
                     shreg_s     = hold_data_s;
                     hold_take_s = 1'b1;
                  end else if (accept_s) begin
                     shreg_s = parallel_in;
                  end else begin
                     state_s = PISO_IDLE;
                  end
`else
                  state_s = PISO_IDLE;
`endif
               end else begin
`ifdef PISO_PRELOAD_EN
                  hold_write_s = accept_s;
`else
                  state_s = PISO_SHIFT;
`endif
               end
            end
            default: begin
               state_s = PISO_IDLE;
            end
         endcase
      end else begin
         state_s = state_r;
      end
   end

   // State, datapath and registered outputs.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= PISO_IDLE;
         shreg_r <= {WIDTH{1'b0}};
         count_r <= {CW{1'b0}};
         bit_r   <= 1'b0;
         valid_r <= 1'b0;
         last_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         shreg_r <= shreg_s;
         count_r <= count_s;
         bit_r   <= bit_s;
         valid_r <= valid_s;
         last_r  <= last_s;
      end
   end

endmodule
